// File: rtl/reverse_diffusion_sequencer.sv
// Time-multiplexes one InvMixColumns column unit over a 128-bit decrypt state.
// Issues columns 0..3, writes the results back in place, then holds the result until it is taken.
module reverse_diffusion_sequencer #(
  parameter int unsigned COL_LAT = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_bypass,
  input  logic [127:0] state_in,
  output logic         col_issue,
  output logic [31:0]  col_data,
  input  logic [31:0]  col_res,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  localparam int unsigned STATE_W = 128;
  localparam int unsigned COL_W   = 32;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned N_ROW   = 4;
  localparam int unsigned CNT_W   = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [STATE_W-1:0] r_work;
  logic [STATE_W-1:0] w_work_nxt;
  logic [CNT_W-1:0]   r_issue_cnt;
  logic [CNT_W-1:0]   w_issue_cnt_nxt;
  logic [CNT_W-1:0]   r_cap_cnt;
  logic [CNT_W-1:0]   w_cap_cnt_nxt;
  logic               r_col_issue;
  logic               w_col_issue_nxt;
  logic [COL_W-1:0]   r_col_data;
  logic [COL_W-1:0]   w_col_data_nxt;
  logic               r_cap_d;
  logic               w_cap_en;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;

  // Gather column c as {byte(3,c),byte(2,c),byte(1,c),byte(0,c)}.
  function automatic logic [COL_W-1:0] get_col(input logic [STATE_W-1:0] s,
                                               input logic [CNT_W-1:0]   c);
    logic [COL_W-1:0] v;
    v = '0;
    for (int r = 0; r < int'(N_ROW); r++) begin
      v[BYTE_W*r +: BYTE_W] = s[BYTE_W*(int'(N_ROW)*r + int'(c)) +: BYTE_W];
    end
    return v;
  endfunction

  // Results arrive in the same cycle as the issue, or one cycle later.
  assign w_cap_en = (COL_LAT == 0) ? r_col_issue : r_cap_d;

  always_comb begin
    w_state_nxt     = r_state;
    w_work_nxt      = r_work;
    w_issue_cnt_nxt = r_issue_cnt;
    w_cap_cnt_nxt   = r_cap_cnt;
    w_col_issue_nxt = 1'b0;
    w_col_data_nxt  = '0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_work_nxt      = state_in;
          w_issue_cnt_nxt = '0;
          w_cap_cnt_nxt   = '0;
          if (in_bypass) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt     = S_RUN;
            w_col_issue_nxt = 1'b1;
            w_col_data_nxt  = get_col(state_in, CNT_W'(0));
          end
        end
      end
      S_RUN: begin
        // Issue counter saturates on column 3; columns ahead of it are still untouched input.
        if (r_col_issue && (r_issue_cnt != CNT_W'(3))) begin
          w_issue_cnt_nxt = r_issue_cnt + CNT_W'(1);
          w_col_issue_nxt = 1'b1;
          w_col_data_nxt  = get_col(r_work, r_issue_cnt + CNT_W'(1));
        end
        if (w_cap_en) begin
          for (int r = 0; r < int'(N_ROW); r++) begin
            w_work_nxt[BYTE_W*(int'(N_ROW)*r + int'(r_cap_cnt)) +: BYTE_W] =
              col_res[BYTE_W*r +: BYTE_W];
          end
          if (r_cap_cnt == CNT_W'(3)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_cap_cnt_nxt = r_cap_cnt + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_work      <= '0;
      r_issue_cnt <= '0;
      r_cap_cnt   <= '0;
      r_col_issue <= 1'b0;
      r_col_data  <= '0;
      r_cap_d     <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_work      <= w_work_nxt;
      r_issue_cnt <= w_issue_cnt_nxt;
      r_cap_cnt   <= w_cap_cnt_nxt;
      r_col_issue <= w_col_issue_nxt;
      r_col_data  <= w_col_data_nxt;
      r_cap_d     <= r_col_issue;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  assign in_ready  = r_in_ready;
  assign col_issue = r_col_issue;
  assign col_data  = r_col_data;
  assign out_valid = r_out_valid;
  assign state_out = r_work;
  assign busy      = r_busy;

endmodule

// File: tb/tb_reverse_diffusion_sequencer.sv
// Bench for reverse_diffusion_sequencer: instance 0 uses COL_LAT=0, instance 1 uses COL_LAT=1,
// each driven by its own InvMixColumns column-unit model.
module tb_reverse_diffusion_sequencer;

  typedef struct {
    logic [127:0] data;
    bit           byp;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid  [2];
  logic         in_ready  [2];
  logic         in_bypass [2];
  logic [127:0] state_in  [2];
  logic         col_issue [2];
  logic [31:0]  col_data  [2];
  logic [31:0]  col_res0;
  logic [31:0]  col_res1;
  logic         out_valid [2];
  logic         out_ready [2];
  logic [127:0] state_out [2];
  logic         busy      [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  exp_t        exp_q   [2][$];
  int          acc_q   [2][$];
  int          hs_q    [2][$];
  logic [31:0] col_log [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input int k);
    logic [7:0] m2, m4, m8;
    m2 = xt(a);
    m4 = xt(m2);
    m8 = xt(m4);
    case (k)
      9:       return m8 ^ a;
      11:      return m8 ^ m2 ^ a;
      13:      return m8 ^ m4 ^ a;
      default: return m8 ^ m4 ^ m2;
    endcase
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3;
    a0 = c[7:0]; a1 = c[15:8]; a2 = c[23:16]; a3 = c[31:24];
    b0 = gmul(a0, 14) ^ gmul(a1, 11) ^ gmul(a2, 13) ^ gmul(a3, 9);
    b1 = gmul(a0, 9)  ^ gmul(a1, 14) ^ gmul(a2, 11) ^ gmul(a3, 13);
    b2 = gmul(a0, 13) ^ gmul(a1, 9)  ^ gmul(a2, 14) ^ gmul(a3, 11);
    b3 = gmul(a0, 11) ^ gmul(a1, 13) ^ gmul(a2, 9)  ^ gmul(a3, 14);
    return {b3, b2, b1, b0};
  endfunction

  function automatic logic [127:0] inv_state(input logic [127:0] s);
    logic [127:0] o;
    logic [31:0]  c, m;
    o = '0;
    for (int col = 0; col < 4; col++) begin
      for (int r = 0; r < 4; r++) c[8*r +: 8] = s[8*(4*r+col) +: 8];
      m = inv_col(c);
      for (int r = 0; r < 4; r++) o[8*(4*r+col) +: 8] = m[8*r +: 8];
    end
    return o;
  endfunction

  // Column unit models: combinational for COL_LAT=0, one register stage for COL_LAT=1.
  assign col_res0 = col_issue[0] ? inv_col(col_data[0]) : 'x;
  always @(posedge clk) col_res1 <= col_issue[1] ? inv_col(col_data[1]) : 'x;

  reverse_diffusion_sequencer #(.COL_LAT(0)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_bypass(in_bypass[0]), .state_in(state_in[0]), .col_issue(col_issue[0]),
    .col_data(col_data[0]), .col_res(col_res0), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .state_out(state_out[0]), .busy(busy[0])
  );

  reverse_diffusion_sequencer #(.COL_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_bypass(in_bypass[1]), .state_in(state_in[1]), .col_issue(col_issue[1]),
    .col_data(col_data[1]), .col_res(col_res1), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .state_out(state_out[1]), .busy(busy[1])
  );

  // Scoreboard: latency checked at the first edge out_valid is seen, data at the handshake.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    bit prev_ov = 1'b0;
    always @(negedge clk) begin
      int   lat;
      int   explat;
      exp_t e;
      if (reset) begin
        prev_ov = 1'b0;
      end else begin
        if (in_valid[g] && in_ready[g]) acc_q[g].push_back(cyc + 1);
        if (col_issue[g]) col_log[g].push_back(col_data[g]);
        if (out_valid[g] && !prev_ov) begin
          checks++;
          if (exp_q[g].size() == 0 || acc_q[g].size() == 0) begin
            failures++;
            $display("FAIL unexpected_out inst=%0d out_valid rose with nothing pending", g);
          end else begin
            lat = cyc + 1 - acc_q[g].pop_front();
            explat = exp_q[g][0].byp ? 1 : 5 + g;
            if (lat !== explat) begin
              failures++;
              $display("FAIL latency inst=%0d got=%0d exp=%0d", g, lat, explat);
            end
          end
        end
        if (out_valid[g] && out_ready[g] && exp_q[g].size() > 0) begin
          e = exp_q[g].pop_front();
          checks++;
          if (state_out[g] !== e.data) begin
            failures++;
            $display("FAIL state_out inst=%0d got=%h exp=%h", g, state_out[g], e.data);
          end
          hs_q[g].push_back(cyc + 1);
        end
        prev_ov = out_valid[g];
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int d, input logic [127:0] s, input bit byp,
                      input logic [127:0] exp_data, input bit track);
    int   n;
    exp_t e;
    state_in[d] = s;
    in_bypass[d] = byp;
    in_valid[d] = 1'b1;
    if (track) begin
      e.data = exp_data;
      e.byp = byp;
      exp_q[d].push_back(e);
    end
    n = 0;
    while (!in_ready[d] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready[d]) begin
      checks++; failures++;
      $display("FAIL send_timeout inst=%0d in_ready=%b exp=1", d, in_ready[d]);
    end
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while (exp_q[d].size() > 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q[d].size() > 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout inst=%0d pending=%0d exp=0", d, exp_q[d].size());
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      checks += 6;
      if (in_ready[d] !== 1'b1) begin failures++; $display("FAIL rst_in_ready inst=%0d got=%b exp=1", d, in_ready[d]); end
      if (out_valid[d] !== 1'b0) begin failures++; $display("FAIL rst_out_valid inst=%0d got=%b exp=0", d, out_valid[d]); end
      if (col_issue[d] !== 1'b0) begin failures++; $display("FAIL rst_col_issue inst=%0d got=%b exp=0", d, col_issue[d]); end
      if (col_data[d] !== 32'h0) begin failures++; $display("FAIL rst_col_data inst=%0d got=%h exp=0", d, col_data[d]); end
      if (state_out[d] !== 128'h0) begin failures++; $display("FAIL rst_state_out inst=%0d got=%h exp=0", d, state_out[d]); end
      if (busy[d] !== 1'b0) begin failures++; $display("FAIL rst_busy inst=%0d got=%b exp=0", d, busy[d]); end
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_all_columns();
    for (int d = 0; d < 2; d++) begin
      send(d, 128'hbcbcbcbc_a1a1a1a1_4d4d4d4d_8e8e8e8e, 1'b0,
           128'h45454545_53535353_13131313_dbdbdbdb, 1'b1);
      drain(d);
    end
  endtask

  task automatic test_single_column();
    logic [31:0] exp_cols [4];
    exp_cols[0] = 32'h9d58dc9f;
    exp_cols[1] = 32'h01010101;
    exp_cols[2] = 32'h01010101;
    exp_cols[3] = 32'h01010101;
    for (int d = 0; d < 2; d++) begin
      col_log[d].delete();
      send(d, 128'h0101019d_01010158_010101dc_0101019f, 1'b0,
           128'h0101015c_01010122_0101010a_010101f2, 1'b1);
      drain(d);
      checks++;
      if (col_log[d].size() != 4) begin
        failures++;
        $display("FAIL issue_count inst=%0d got=%0d exp=4", d, col_log[d].size());
      end else begin
        for (int i = 0; i < 4; i++) begin
          checks++;
          if (col_log[d][i] !== exp_cols[i]) begin
            failures++;
            $display("FAIL col_order inst=%0d idx=%0d got=%h exp=%h", d, i, col_log[d][i], exp_cols[i]);
          end
        end
      end
    end
  endtask

  task automatic test_bypass();
    for (int d = 0; d < 2; d++) begin
      col_log[d].delete();
      send(d, 128'h00112233_44556677_8899aabb_ccddeeff, 1'b1,
           128'h00112233_44556677_8899aabb_ccddeeff, 1'b1);
      drain(d);
      checks++;
      if (col_log[d].size() != 0) begin
        failures++;
        $display("FAIL bypass_issue inst=%0d got=%0d exp=0", d, col_log[d].size());
      end
    end
  endtask

  task automatic test_stall();
    logic [127:0] s, e;
    int n;
    s = {$urandom, $urandom, $urandom, $urandom};
    e = inv_state(s);
    out_ready[0] = 1'b0;
    send(0, s, 1'b0, e, 1'b1);
    n = 0;
    while (!out_valid[0] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (out_valid[0] !== 1'b1) begin failures++; $display("FAIL stall_wait got=%b exp=1", out_valid[0]); end
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = (i == 2 || i == 5);
      state_in[0] = ~s;
      checks++;
      if (out_valid[0] !== 1'b1 || state_out[0] !== e || in_ready[0] !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d ov=%b ir=%b got=%h exp=%h", i, out_valid[0], in_ready[0], state_out[0], e);
      end
      @(posedge clk); #1;
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    checks++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL stall_release ir=%b ov=%b busy=%b exp=1,0,0", in_ready[0], out_valid[0], busy[0]);
    end
    @(posedge clk); #1;
    checks++;
    if (exp_q[0].size() != 0) begin failures++; $display("FAIL stall_pending got=%0d exp=0", exp_q[0].size()); end
    out_ready[0] = 1'b1;
  endtask

  task automatic test_reset_mid_run();
    logic [127:0] sa, sb;
    sa = {$urandom, $urandom, $urandom, $urandom};
    sb = {$urandom, $urandom, $urandom, $urandom};
    send(0, sa, 1'b0, 128'h0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks += 6;
    if (in_ready[0] !== 1'b1) begin failures++; $display("FAIL mid_in_ready got=%b exp=1", in_ready[0]); end
    if (out_valid[0] !== 1'b0) begin failures++; $display("FAIL mid_out_valid got=%b exp=0", out_valid[0]); end
    if (col_issue[0] !== 1'b0) begin failures++; $display("FAIL mid_col_issue got=%b exp=0", col_issue[0]); end
    if (col_data[0] !== 32'h0) begin failures++; $display("FAIL mid_col_data got=%h exp=0", col_data[0]); end
    if (state_out[0] !== 128'h0) begin failures++; $display("FAIL mid_state_out got=%h exp=0", state_out[0]); end
    if (busy[0] !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy[0]); end
    @(posedge clk); #1;
    reset = 1'b0;
    acc_q[0].delete();
    exp_q[0].delete();
    @(posedge clk); #1;
    send(0, sb, 1'b0, inv_state(sb), 1'b1);
    drain(0);
  endtask

  task automatic test_back_to_back();
    logic [127:0] s;
    for (int d = 0; d < 2; d++) begin
      hs_q[d].delete();
      for (int k = 0; k < 3; k++) begin
        s = {$urandom, $urandom, $urandom, $urandom};
        send(d, s, 1'b0, inv_state(s), 1'b1);
      end
      drain(d);
      checks++;
      if (hs_q[d].size() != 3) begin
        failures++;
        $display("FAIL b2b_count inst=%0d got=%0d exp=3", d, hs_q[d].size());
      end else begin
        for (int k = 1; k < 3; k++) begin
          checks++;
          if (hs_q[d][k] - hs_q[d][k-1] != 6 + d) begin
            failures++;
            $display("FAIL b2b_period inst=%0d got=%0d exp=%0d", d, hs_q[d][k] - hs_q[d][k-1], 6 + d);
          end
        end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0;
      in_bypass[d] = 1'b0;
      state_in[d] = '0;
      out_ready[d] = 1'b1;
    end
    test_reset();
    test_all_columns();
    test_single_column();
    test_bypass();
    test_stall();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
